// File: rtl/scan_ctrl.sv
// scan_ctrl: debounced up/down display-mode selector for the VGA path.
// Pending mode changes are committed to sdata only at frame_start.
module scan_ctrl #(
  parameter int DB_CYCLES = 20,
  parameter int NUM_MODES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN_in1,
  input  logic       EN_in0,
  input  logic       frame_start,
  output logic [1:0] sdata,
  output logic       pending,
  output logic       commit
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t state, state_d;

  logic [1:0] btn;
  logic [1:0] sync1, sync2;
  logic [1:0] db, db_q;
  logic [CW-1:0] cnt [2];

  logic req_up, req_dn, req_any;
  logic [1:0] next_mode, mode_step;
  logic [1:0] next_mode_d, sdata_d;
  logic commit_d;

  assign btn = {EN_in1, EN_in0};

  // Index 1 is the "next" button, index 0 the "previous" button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign req_up  = db[1] & ~db_q[1];
  assign req_dn  = db[0] & ~db_q[0];
  assign req_any = req_up ^ req_dn;

  always_comb begin
    mode_step = next_mode;
    unique case (1'b1)
      (req_up & ~req_dn):
        mode_step = (next_mode == MODE_LAST) ? 2'd0 : next_mode + 2'd1;
      (req_dn & ~req_up):
        mode_step = (next_mode == 2'd0) ? MODE_LAST : next_mode - 2'd1;
      default:
        mode_step = next_mode;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      next_mode <= '0;
      sdata     <= '0;
      commit    <= 1'b0;
    end else begin
      state     <= state_d;
      next_mode <= next_mode_d;
      sdata     <= sdata_d;
      commit    <= commit_d;
    end
  end

  // A request racing frame_start in IDLE waits for the next frame.
  always_comb begin
    state_d     = state;
    next_mode_d = mode_step;
    sdata_d     = sdata;
    commit_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_any) state_d = PEND;
      end
      PEND: begin
        if (frame_start) begin
          sdata_d  = mode_step;
          commit_d = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  assign pending = (state == PEND);

endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: directed bench for scan_ctrl.
// Two instances share stimulus: 4 modes and 3 modes, DB_CYCLES=4.
module tb_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic EN_in1, EN_in0, frame_start;
  logic [1:0] sdata4, sdata3;
  logic pending4, pending3;
  logic commit4, commit3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scan_ctrl #(.DB_CYCLES(4), .NUM_MODES(4)) dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .EN_in1(EN_in1),
    .EN_in0(EN_in0),
    .frame_start(frame_start),
    .sdata(sdata4),
    .pending(pending4),
    .commit(commit4)
  );

  scan_ctrl #(.DB_CYCLES(4), .NUM_MODES(3)) dut3 (
    .clk(clk),
    .rst_n(rst_n),
    .EN_in1(EN_in1),
    .EN_in0(EN_in0),
    .frame_start(frame_start),
    .sdata(sdata3),
    .pending(pending3),
    .commit(commit3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic up, input logic dn);
    EN_in1 = up;
    EN_in0 = dn;
    tick(10);
    EN_in1 = 1'b0;
    EN_in0 = 1'b0;
    tick(10);
  endtask

  task automatic pend(input string tag, input int p4, input int p3);
    check({tag, ".pend4"}, int'(pending4), p4);
    check({tag, ".pend3"}, int'(pending3), p3);
  endtask

  task automatic frame(input string tag, input int c,
                       input int s4, input int s3);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check({tag, ".commit4"}, int'(commit4), c);
    check({tag, ".commit3"}, int'(commit3), c);
    check({tag, ".sdata4"}, int'(sdata4), s4);
    check({tag, ".sdata3"}, int'(sdata3), s3);
    pend(tag, 0, 0);
    tick();
    check({tag, ".commit4_off"}, int'(commit4), 0);
    check({tag, ".commit3_off"}, int'(commit3), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    EN_in1 = 1'b0;
    EN_in0 = 1'b0;
    frame_start = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("rst.sdata4", int'(sdata4), 0);
    check("rst.commit4", int'(commit4), 0);
    pend("rst", 0, 0);

    // t1: clean press, req after 2+4 cycles, pending one cycle later
    EN_in1 = 1'b1;
    tick(6);
    pend("t1.early", 0, 0);
    tick();
    pend("t1.late", 1, 1);
    tick(13);
    EN_in1 = 1'b0;
    tick(10);
    frame("t1", 1, 1, 1);

    // t2: glitches never stable for 4 cycles
    EN_in1 = 1'b1;
    tick(3);
    EN_in1 = 1'b0;
    tick();
    EN_in1 = 1'b1;
    tick(2);
    EN_in1 = 1'b0;
    tick(10);
    pend("t2", 0, 0);
    frame("t2", 0, 1, 1);

    // t3: down twice (wrap), three ups, then one up (3-mode wrap)
    press(1'b0, 1'b1);
    frame("t3a", 1, 0, 0);
    press(1'b0, 1'b1);
    frame("t3b", 1, 3, 2);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    frame("t3c", 1, 2, 2);
    press(1'b1, 1'b0);
    frame("t3d", 1, 3, 0);

    // t4: simultaneous presses cancel; up then down commits same value
    press(1'b1, 1'b1);
    pend("t4a", 0, 0);
    frame("t4a", 0, 3, 0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    pend("t4b", 1, 1);
    frame("t4b", 1, 3, 0);

    // t5: req aligned with frame_start in PEND, then in IDLE
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    EN_in1 = 1'b1;
    tick(6);
    frame("t5a", 1, 2, 0);
    EN_in1 = 1'b0;
    tick(10);
    EN_in1 = 1'b1;
    tick(6);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t5b.commit4", int'(commit4), 0);
    check("t5b.commit3", int'(commit3), 0);
    pend("t5b", 1, 1);
    EN_in1 = 1'b0;
    tick(10);
    frame("t5c", 1, 3, 1);

    // t6: reset in PEND, then button held through reset
    press(1'b1, 1'b0);
    pend("t6a", 1, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6.sdata4", int'(sdata4), 0);
    check("t6.sdata3", int'(sdata3), 0);
    check("t6.commit4", int'(commit4), 0);
    pend("t6b", 0, 0);
    frame("t6c", 0, 0, 0);
    EN_in1 = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(6);
    pend("t6d.early", 0, 0);
    tick();
    pend("t6d.late", 1, 1);
    EN_in1 = 1'b0;
    tick(10);
    frame("t6e", 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
Synchronous controller for the 2-bit display-mode selector in the VGA path. Two raw push-button requesters pass through synchronisers and debouncers. Their press events are arbitrated into an up/down pending mode. The pending mode is committed to sdata only at a frame boundary, so the displayed image never changes mid-frame. Downstream pattern/image muxes consume sdata unchanged.

Parameters:
DB_CYCLES, 20, consecutive clk cycles a synchronised button level must differ from its debounced level before it is accepted (>=1)
NUM_MODES, 4, number of selectable modes (2..4); mode values 0..NUM_MODES-1

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
EN_in1  input  1  raw "next mode" button, asynchronous, active-high
EN_in0  input  1  raw "previous mode" button, asynchronous, active-high
frame_start  input  1  one-cycle pulse at the start of vertical blanking, synchronous to clk
sdata  output  2  committed display mode
pending  output  1  high while an uncommitted mode change is held
commit  output  1  one-cycle pulse on the cycle sdata is loaded

Behaviour:
- Reset (rst_n=0 at a clk edge): sdata=0, pending=0, commit=0, next_mode=0, FSM=IDLE, both sync flops=0, debounced levels=0, debounce counters=0. Reset asserted mid-debounce or in PEND discards all in-flight state.
- Sync: each button passes through a 2-flop synchroniser. EN_in1 and EN_in0 have independent paths.
- Debounce, per button:
  - If the sync level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 while the level still differs, the debounced level flips and the counter clears.
  - Counter width is clog2(DB_CYCLES+1).
- Event: a 0->1 transition of a debounced level produces a one-cycle req pulse (req_up from EN_in1, req_dn from EN_in0). Releases produce no event.
- Latency: a clean press is visible at sync output 2 cycles after it is applied. req asserts DB_CYCLES cycles after that.
- Arbitration:
  - req_up only: next_mode = (next_mode==NUM_MODES-1) ? 0 : next_mode+1.
  - req_dn only: next_mode = (next_mode==0) ? NUM_MODES-1 : next_mode-1.
  - Both in the same cycle: they cancel. next_mode holds, and the cycle does not count as a request for the FSM.
- FSM:
  - IDLE: on a valid request, update next_mode, go to PEND, pending=1 from the next cycle. A frame_start in the same cycle is ignored, so the commit waits for the next frame_start.
  - PEND: further requests keep updating next_mode (accumulate). On frame_start: sdata <= next_mode, including any request arriving in that same cycle. Also commit=1 for one cycle, pending=0, go to IDLE.
  - If accumulated requests return next_mode to the current sdata value, the commit still occurs. commit pulses and sdata value is unchanged.
- In IDLE, next_mode always equals sdata.
- frame_start in IDLE without a request has no effect.
- commit is never high for two consecutive cycles. pending and commit are never both high.
- sdata is only ever in 0..NUM_MODES-1 and changes only on a cycle where commit=1.

Test Plan (DB_CYCLES=4, NUM_MODES=4 unless noted):
1. Reset, then hold EN_in1=1 for 20 cycles, then pulse frame_start -> req_up 6 cycles after the press. pending=1 the next cycle. On the frame_start edge sdata=1, commit=1 for exactly 1 cycle, pending=0.
2. EN_in1 glitches high for 3 cycles, low for 1, high for 2 (never 4 stable), then frame_start -> no req, pending stays 0, sdata stays 0, no commit.
3. From sdata=0, one EN_in0 press then frame_start -> sdata=3 (wrap down). Next, three EN_in1 presses then one frame_start -> sdata=2, a single commit pulse. Repeat with NUM_MODES=3 from sdata=2 and one EN_in1 press -> sdata=0.
4. Press both buttons with identical timing -> both debounced on the same cycle. No next_mode change, pending stays 0, frame_start produces no commit. Separately in PEND: EN_in1 press then EN_in0 press -> commit with sdata unchanged.
5. In PEND with next_mode=1, align a third req_up with frame_start -> sdata=2 on that edge. In IDLE, align req_up with frame_start -> no commit then; the commit happens at the following frame_start.
6. In PEND, assert rst_n=0 for 1 cycle -> sdata=0, pending=0, commit=0. A subsequent frame_start produces no commit. A button held through the reset re-debounces and requests again after 2+4 cycles.
